vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data enable, pixel request stream,
// border colour, line/frame markers and a built-in colour-bar test pattern.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 12,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int REQ_LEAD = 1,
  parameter logic [DATA_W-1:0] BORDER_RGB = '0
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              test_mode,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK + H_LEFT;
  localparam int VA      = V_SYNC + V_BACK + V_TOP;
  localparam int BAR_W   = H_VALID / 8;

  logic [CNT_W-1:0]  cnt_h;
  logic [CNT_W-1:0]  cnt_v;
  logic              test_latched;
  logic [CNT_W-1:0]  bar_cnt;
  logic [2:0]        bar_idx;

  logic              h_end;
  logic              v_end;
  logic              h_act;
  logic              v_act;
  logic              active;
  logic              border;
  logic [CNT_W:0]    lead_h;
  logic              lead_act;
  logic [CNT_W-1:0]  req_x;
  logic [CNT_W-1:0]  req_y;
  logic [DATA_W-1:0] bar_rgb;

  always_comb begin
    h_end    = (cnt_h == CNT_W'(H_TOTAL - 1));
    v_end    = (cnt_v == CNT_W'(V_TOTAL - 1));
    h_act    = (cnt_h >= CNT_W'(HA)) && (cnt_h < CNT_W'(HA + H_VALID));
    v_act    = (cnt_v >= CNT_W'(VA)) && (cnt_v < CNT_W'(VA + V_VALID));
    active   = h_act && v_act;
    border   = (cnt_h >= CNT_W'(H_SYNC + H_BACK)) && (cnt_h < CNT_W'(HA + H_VALID + H_RIGHT)) &&
               (cnt_v >= CNT_W'(V_SYNC + V_BACK)) && (cnt_v < CNT_W'(VA + V_VALID + V_BOTTOM)) &&
               !active;
    // One extra bit so the look-ahead column never wraps near the end of a line
    lead_h   = {1'b0, cnt_h} + (CNT_W + 1)'(REQ_LEAD);
    lead_act = (lead_h >= (CNT_W + 1)'(HA)) && (lead_h < (CNT_W + 1)'(HA + H_VALID)) && v_act;
    req_x    = cnt_h + CNT_W'(REQ_LEAD) - CNT_W'(HA);
    req_y    = cnt_v - CNT_W'(VA);
  end

  always_comb begin
    bar_rgb = '0;
    case (bar_idx)
      3'd0:    bar_rgb = DATA_W'(16'hFFFF);
      3'd1:    bar_rgb = DATA_W'(16'hFFE0);
      3'd2:    bar_rgb = DATA_W'(16'h07FF);
      3'd3:    bar_rgb = DATA_W'(16'h07E0);
      3'd4:    bar_rgb = DATA_W'(16'hF81F);
      3'd5:    bar_rgb = DATA_W'(16'hF800);
      3'd6:    bar_rgb = DATA_W'(16'h001F);
      default: bar_rgb = DATA_W'(16'h0000);
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cnt_h        <= '0;
      cnt_v        <= '0;
      test_latched <= 1'b0;
      bar_cnt      <= '0;
      bar_idx      <= '0;
      pix_req      <= 1'b0;
      pix_x        <= '1;
      pix_y        <= '1;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      de           <= 1'b0;
      rgb          <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      cnt_h <= h_end ? '0 : cnt_h + 1'b1;
      if (h_end)
        cnt_v <= v_end ? '0 : cnt_v + 1'b1;

      if (cnt_h == '0 && cnt_v == '0)
        test_latched <= test_mode;

      // Bar position restarts on every non-active cycle, so each active line begins at bar 0
      if (active) begin
        if (bar_cnt == CNT_W'(BAR_W - 1)) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end
      end else begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end

      pix_req     <= lead_act;
      pix_x       <= lead_act ? req_x : '1;
      pix_y       <= lead_act ? req_y : '1;
      hsync       <= (cnt_h < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
      vsync       <= (cnt_v < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
      de          <= active;
      rgb         <= active ? (test_latched ? bar_rgb : pix_data) :
                     border ? BORDER_RGB : '0;
      line_start  <= (cnt_h == '0);
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster with a one-cycle-latency
// pixel source and a two-cycle request lead.
module tb_vga_timing_gen;

  localparam int H_SYNC = 4, H_BACK = 2, H_LEFT = 1, H_VALID = 8, H_RIGHT = 1, H_FRONT = 2;
  localparam int V_SYNC = 1, V_BACK = 1, V_TOP = 1, V_VALID = 4, V_BOTTOM = 1, V_FRONT = 1;
  localparam int H_TOTAL = 18, V_TOTAL = 9, HA = 7, VA = 3;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int LEAD = 2;
  localparam logic [15:0] BORDER = 16'hAAAA;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        test_mode;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_req;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] rgb;
  logic        line_start;
  logic        frame_start;

  typedef struct packed {
    logic        req;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    logic        ls;
    logic        fs;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mh = 0;
  int   mv = 0;
  bit   tm_l = 1'b0;
  logic [15:0] pend = 16'h0000;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_LEFT(H_LEFT), .H_VALID(H_VALID),
    .H_RIGHT(H_RIGHT), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOP(V_TOP), .V_VALID(V_VALID),
    .V_BOTTOM(V_BOTTOM), .V_FRONT(V_FRONT),
    .DATA_W(16), .CNT_W(8), .HS_POL(1'b0), .VS_POL(1'b1),
    .REQ_LEAD(LEAD), .BORDER_RGB(BORDER)
  ) dut (
    .vga_clk(clk), .sys_rst(sys_rst), .test_mode(test_mode), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .line_start(line_start), .frame_start(frame_start)
  );

  function automatic logic [15:0] src(input int x, input int y);
    return 16'h5000 | 16'(y * 16 + x);
  endfunction

  function automatic logic [15:0] bar(input int x);
    case (x)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic out_t expect_at(input int h, input int v, input bit tm);
    out_t o;
    bit h_in = (h >= 7 && h < 15);
    bit v_in = (v >= 3 && v < 7);
    bit box  = (h >= 6 && h < 16) && (v >= 2 && v < 8);
    bit r_in = (h + LEAD >= 7 && h + LEAD < 15) && v_in;
    o.req = r_in;
    o.x   = r_in ? 8'(h + LEAD - HA) : 8'hFF;
    o.y   = r_in ? 8'(v - VA) : 8'hFF;
    o.hs  = (h < 4) ? 1'b0 : 1'b1;
    o.vs  = (v < 1);
    o.de  = h_in && v_in;
    if (h_in && v_in)
      o.rgb = tm ? bar(h - HA) : src(h - HA, v - VA);
    else
      o.rgb = box ? BORDER : 16'h0000;
    o.ls  = (h == 0);
    o.fs  = (h == 0 && v == 0);
    return o;
  endfunction

  // Reference position tracker: queues the output expected after every clock edge
  always @(posedge clk) begin
    if (sys_rst) begin
      exp_q.push_back('{req: 1'b0, x: 8'hFF, y: 8'hFF, hs: 1'b1, vs: 1'b0, de: 1'b0,
                        rgb: 16'h0000, ls: 1'b0, fs: 1'b0});
      mh = 0;
      mv = 0;
      tm_l = 1'b0;
    end else begin
      exp_q.push_back(expect_at(mh, mv, tm_l));
      if (mh == 0 && mv == 0)
        tm_l = test_mode;
      if (mh == H_TOTAL - 1) begin
        mh = 0;
        mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // Pixel source with one cycle of latency after the request cycle
  always @(negedge clk) begin
    pix_data = pend;
    pend = pix_req ? src(int'(pix_x), int'(pix_y)) : 16'hDEAD;
  end

  task automatic checkOutput(input out_t e);
    out_t a;
    a = '{req: pix_req, x: pix_x, y: pix_y, hs: hsync, vs: vsync, de: de,
          rgb: rgb, ls: line_start, fs: frame_start};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL cycle_out t=%0t got req=%b x=%h y=%h hs=%b vs=%b de=%b rgb=%h ls=%b fs=%b exp req=%b x=%h y=%h hs=%b vs=%b de=%b rgb=%h ls=%b fs=%b",
               $time, a.req, a.x, a.y, a.hs, a.vs, a.de, a.rgb, a.ls, a.fs,
               e.req, e.x, e.y, e.hs, e.vs, e.de, e.rgb, e.ls, e.fs);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0)
      checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic rst, input logic tm, input int cycles);
    sys_rst = rst;
    test_mode = tm;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitPos(input int h, input int v);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (mh == h && mv == v) return;
    end
    miscompares++;
    $display("[TB] FAIL wait_pos got timeout exp h=%0d v=%0d", h, v);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 2 * FRAME);
    waitPos(0, VA + 1);
    // Raised mid-frame: this frame keeps source data, the next shows bars
    applyStimulus(1'b0, 1'b1, 2 * FRAME);
    waitPos(HA + 3, VA + 2);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, FRAME / 2);
    applyStimulus(1'b0, 1'b0, 3 * FRAME);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
